// File: rtl/ram_stream_reader_if.sv
// RAM read port and byte-stream bundle for ram_stream_reader.
// master = reader side (drives RAM strobe/address and the stream), slave = RAM + sink side.
interface ram_stream_reader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              ram_cs;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output ram_cs, ram_addr, m_data, m_valid,
        input  ram_data, m_ready
    );

    modport slave (
        input  ram_cs, ram_addr, m_data, m_valid,
        output ram_data, m_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a block of bytes out of a synchronous-read RAM through a 2-entry FIFO,
// issuing reads only when the FIFO is guaranteed room for the returning data.
module ram_stream_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    ram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [ADDR_W:0]               rd_left_q, rd_left_d;
    logic [ADDR_W:0]               acc_left_q, acc_left_d;
    logic                          pend_q, pend_d;
    logic [1:0][DATA_W-1:0]        fifo_q, fifo_d;
    logic                          rd_ptr_q, rd_ptr_d;
    logic                          wr_ptr_q, wr_ptr_d;
    logic [1:0]                    cnt_q, cnt_d;

    logic                          pop;
    logic                          issue;
    logic [1:0]                    occ_after;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_left_d  = rd_left_q;
        acc_left_d = acc_left_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        pop       = (cnt_q != 2'd0) && bus.m_ready;
        // Occupancy counts the slot freed by this cycle's pop so a steady
        // stream can keep one read in flight every cycle.
        occ_after = cnt_q - {1'b0, pop};
        issue     = (state_q == RUN) && (rd_left_q != '0) && (cnt_q != 2'd2) &&
                    ((occ_after + {1'b0, pend_q}) < 2'd2);
        pend_d    = issue;

        if (issue) begin
            addr_d    = addr_q + ADDR_ONE;
            rd_left_d = rd_left_q - CNT_ONE;
        end
        // pend_q marks that ram_data now holds the previous cycle's read
        if (pend_q) begin
            fifo_d[wr_ptr_q] = bus.ram_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            acc_left_d = acc_left_q - CNT_ONE;
        end
        cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, pop};

        case (state_q)
            IDLE: if (start) begin
                addr_d     = base_addr;
                rd_left_d  = length;
                acc_left_d = length;
                state_d    = (length == '0) ? DONE : RUN;
            end
            RUN:     if (pop && (acc_left_q == CNT_ONE)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_left_q  <= '0;
            acc_left_q <= '0;
            pend_q     <= 1'b0;
            fifo_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_left_q  <= rd_left_d;
            acc_left_q <= acc_left_d;
            pend_q     <= pend_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign bus.ram_cs   = issue;
    assign bus.ram_addr = addr_q;
    assign bus.m_valid  = (cnt_q != 2'd0);
    assign bus.m_data   = fifo_q[rd_ptr_q];
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, RAM address width (512-entry buffer).
REQ-002 SHALL have parameter DATA_W, default 8, byte width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to stream one block.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: first RAM address, sampled with start.
REQ-007 SHALL have port length, input, ADDR_W+1 bits: byte count, 0..512, sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: transfer in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.
REQ-010 SHALL have port ram_cs, output, 1 bit: read strobe to the RAM read port.
REQ-011 SHALL have port ram_addr, output, ADDR_W bits: read address to the RAM read port.
REQ-012 SHALL have port ram_data, input, DATA_W bits: RAM read data, valid one cycle after ram_cs.
REQ-013 SHALL have port m_data, output, DATA_W bits: stream byte.
REQ-014 SHALL have port m_valid, output, 1 bit: m_data valid.
REQ-015 SHALL have port m_ready, input, 1 bit: sink accepts; a transfer occurs when m_valid && m_ready at an edge.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 SHALL, in IDLE, sample start=1 together with base_addr and length, and enter RUN, or enter DONE directly when length=0.
REQ-018 SHALL ignore start while busy=1; the sampled parameters SHALL remain unchanged.
REQ-019 SHALL, in RUN, issue a read (ram_cs=1, ram_addr=current address) in any cycle where reads remaining>0 and buffer occupancy + reads in flight < 2.
REQ-020 SHALL increment the read address by 1 per issued read, modulo 2^ADDR_W (address 511 wraps to 0).
REQ-021 SHALL capture ram_data into a 2-entry output FIFO at the edge following each issued read; data order SHALL equal address order.
REQ-022 SHALL assert m_valid whenever the FIFO is non-empty and SHALL drive m_data from the FIFO head.
REQ-023 SHALL hold m_data/m_valid stable until accepted whenever m_ready=0; no byte lost or duplicated.
REQ-024 SHALL, with m_ready held 1, sustain one byte per cycle; the first m_valid SHALL appear 2 cycles after the start edge.
REQ-025 SHALL allow a simultaneous FIFO push and pop in one cycle, with occupancy unchanged.
REQ-026 SHALL drive ram_cs=0 whenever no read is issued; ram_addr is don't-care then.
REQ-027 SHALL transition RUN->DONE on the edge where the final byte (count = length) is accepted.
REQ-028 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; busy=1 in RUN and DONE, 0 in IDLE.
REQ-029 SHALL treat length=512 as a full-buffer transfer, reading each address exactly once, wrapping from base_addr.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-transfer, immediately force IDLE, busy=0, done=0, ram_cs=0, m_valid=0, FIFO empty, counters 0, m_data=0.
REQ-031 SHALL, after rst_n deasserts, perform no RAM read and no stream output until a new start.

Verification
REQ-032 SHALL verify: RAM preloaded mem[i]=i[7:0], base=0x010, length=4, m_ready=1 -> ram_addr 0x010..0x013 on consecutive cycles, m_data 0x10,0x11,0x12,0x13 on consecutive cycles from start+2, done pulse one cycle after last accept.
REQ-033 SHALL verify: base=0x1FE, length=4 -> reads 0x1FE,0x1FF,0x000,0x001; m_data 0xFE,0xFF,0x00,0x01.
REQ-034 SHALL verify: length=8, m_ready toggling 1,0,0,1,... -> all 8 bytes in order, none dropped or duplicated, at most 2 reads outstanding, ram_cs=0 while the FIFO is full.
REQ-035 SHALL verify: length=0 -> no ram_cs and no m_valid; done=1 exactly 1 cycle after the start edge; busy=1 for that cycle only.
REQ-036 SHALL verify: start pulsed again mid-transfer with different base/length -> ignored; original 6-byte transfer completes unchanged.
REQ-037 SHALL verify: rst_n=0 asserted after 3 of 10 bytes -> outputs reach reset values without a clock edge; a new start with base=0x000, length=2 then yields 0x00,0x01 and done.
